// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // master: the loader, consuming bytes and driving memory writes
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // slave: the byte source and the instruction memory
  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles an MSB-first byte stream into words and writes them to instruction memory
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              abort_i,
  imem_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;

  logic                in_ready;
  logic                mem_we;
  logic                busy;
  logic                done;
  logic [ADDR_W+1:0]   end_addr;
  logic [ADDR_W:0]     word_cnt_inc;

  assign end_addr     = {2'b00, base_addr_i} + {1'b0, length_i};
  assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    err_d       = err_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort wins over a coincident start
        if (start_i && !abort_i) begin
          addr_d     = base_addr_i;
          len_d      = length_i;
          shift_d    = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
          if (length_i == '0 || end_addr > (ADDR_W+2)'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RECV;
          end
        end
      end

      S_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.in_valid) begin
          shift_d    = {shift_q[DATA_W-9:0], bus.in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        busy = 1'b1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_we      = 1'b1;
          word_cnt_d  = word_cnt_inc;
          last_addr_d = addr_q;
          last_data_d = shift_q;
          if (word_cnt_inc == len_q) begin
            state_d = S_DONE;
          end else begin
            // the last word never increments, so the address cannot wrap
            addr_d     = addr_q + (ADDR_W)'(1);
            byte_cnt_d = '0;
            state_d    = S_RECV;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      err_q       <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Bus shows the live word only while writing; otherwise it holds the last write.
  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_we ? addr_q  : last_addr_q;
  assign bus.mem_wdata = mem_we ? shift_q : last_data_q;

  assign busy_o        = busy;
  assign done_o        = done;
  assign err_o         = err_q;
  assign word_count_o  = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done, err;
  logic [ADDR_W:0]   word_count;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .length_i     (length),
    .abort_i      (abort),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write/handshake/done monitor, sampling 3 ns after each falling edge
  int          cyc = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wcyc[$];
  int          hs[$];

  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      wcyc.push_back(cyc);
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs.push_back(cyc);
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] byte_of(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  function automatic logic [31:0] word_of(input int k0);
    return {byte_of(k0), byte_of(k0 + 1), byte_of(k0 + 2), byte_of(k0 + 3)};
  endfunction

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    wcyc.delete();
    hs.delete();
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("push_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n0;
    int i;
    n0 = n_done;
    i  = 0;
    while (n_done == n0 && i < limit) begin
      @(negedge clk);
      #4;
      i++;
    end
    check("done_seen", n_done - n0, 32'd1);
  endtask

  initial begin
    int n0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // reset, with start held high to show it is ignored
    start = 1'b1;
    #23;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_word_count", {23'd0, word_count}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single word
    clear_logs();
    do_start(8'h00, 9'd1);
    #1 check("s1_busy", {31'd0, busy}, 32'd1);
    push_byte(8'h0C);
    push_byte(8'h01);
    push_byte(8'h00);
    push_byte(8'h18);
    wait_done(10);
    check("s1_done_level", {31'd0, done}, 32'd1);
    check("s1_n_we", wa.size(), 32'd1);
    check("s1_addr", {24'd0, wa[0]}, 32'h0);
    check("s1_data", wd[0], 32'h0C010018);
    check("s1_we_after_4th", wcyc[0] - hs[3], 32'd1);
    check("s1_done_after_we", done_cyc - wcyc[0], 32'd1);
    check("s1_err", {31'd0, err}, 32'd0);
    check("s1_word_count", {23'd0, word_count}, 32'd1);
    @(negedge clk);
    #1 check("s1_done_width", {31'd0, done}, 32'd0);
    check("s1_busy_idle", {31'd0, busy}, 32'd0);

    // 13 words back to back
    clear_logs();
    do_start(8'h00, 9'd13);
    for (int k = 0; k < 52; k++) push_byte(byte_of(k));
    wait_done(10);
    check("s2_n_we", wa.size(), 32'd13);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("s2_addr%0d", i), {24'd0, wa[i]}, 32'(i));
      check($sformatf("s2_data%0d", i), wd[i], word_of(4 * i));
    end
    check("s2_span", wcyc[12] - hs[0], 32'd64);
    check("s2_word_count", {23'd0, word_count}, 32'd13);
    check("s2_err", {31'd0, err}, 32'd0);

    // stalled stream, with a stray start mid-load
    clear_logs();
    do_start(8'h10, 9'd3);
    for (int k = 0; k < 12; k++) begin
      push_byte(byte_of(k + 100));
      if (k == 5) begin
        start     = 1'b1;
        base_addr = 8'h80;
        length    = 9'd1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(10);
    check("s3_n_we", wa.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s3_addr%0d", i), {24'd0, wa[i]}, 32'h10 + 32'(i));
      check($sformatf("s3_data%0d", i), wd[i], word_of(100 + 4 * i));
    end
    check("s3_word_count", {23'd0, word_count}, 32'd3);

    // rejected parameters
    clear_logs();
    do_start(8'h00, 9'd0);
    #1 check("s4a_done", {31'd0, done}, 32'd1);
    check("s4a_busy", {31'd0, busy}, 32'd0);
    check("s4a_err", {31'd0, err}, 32'd1);
    do_start(8'd250, 9'd7);
    #1 check("s4b_done", {31'd0, done}, 32'd1);
    check("s4b_err", {31'd0, err}, 32'd1);
    check("s4b_word_count", {23'd0, word_count}, 32'd0);
    @(negedge clk);
    #1 check("s4_no_we", wa.size(), 32'd0);
    do_start(8'd255, 9'd1);
    #1 check("s4c_err_cleared", {31'd0, err}, 32'd0);
    push_byte(8'hDE);
    push_byte(8'hAD);
    push_byte(8'hBE);
    push_byte(8'hEF);
    wait_done(10);
    check("s4c_addr", {24'd0, wa[0]}, 32'd255);
    check("s4c_data", wd[0], 32'hDEADBEEF);

    // abort after 2 bytes of word 3
    clear_logs();
    do_start(8'h20, 9'd5);
    for (int k = 0; k < 14; k++) push_byte(byte_of(k + 200));
    n0 = n_done;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_err", {31'd0, err}, 32'd1);
    check("s5_word_count", {23'd0, word_count}, 32'd3);
    #3 check("s5_n_we", wa.size(), 32'd3);
    check("s5_no_done", n_done - n0, 32'd0);

    // abort while WRITE is active: strobe suppressed, bus holds last write
    do_start(8'h40, 9'd2);
    #1 check("s5w_err_cleared", {31'd0, err}, 32'd0);
    for (int k = 0; k < 4; k++) push_byte(8'(k + 1));
    abort = 1'b1;
    #1 check("s5w_we_forced", {31'd0, bus.mem_we}, 32'd0);
    check("s5w_addr_hold", {24'd0, bus.mem_addr}, 32'h22);
    check("s5w_data_hold", bus.mem_wdata, word_of(208));
    @(negedge clk);
    abort = 1'b0;
    #1 check("s5w_busy", {31'd0, busy}, 32'd0);
    check("s5w_err", {31'd0, err}, 32'd1);

    // abort and start together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    base_addr = 8'h70;
    length = 9'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1 check("s5s_busy", {31'd0, busy}, 32'd0);
    check("s5s_done", {31'd0, done}, 32'd0);
    check("s5s_err_kept", {31'd0, err}, 32'd1);

    // following start clears err and loads normally
    clear_logs();
    do_start(8'h30, 9'd1);
    #1 check("s5n_err", {31'd0, err}, 32'd0);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    wait_done(10);
    check("s5n_addr", {24'd0, wa[0]}, 32'h30);
    check("s5n_data", wd[0], 32'h12345678);

    // reset during WRITE
    do_start(8'h50, 9'd2);
    for (int k = 0; k < 4; k++) push_byte(8'hA0 + 8'(k));
    #1 check("s6_we_before", {31'd0, bus.mem_we}, 32'd1);
    check("s6_addr_before", {24'd0, bus.mem_addr}, 32'h50);
    rst_n = 1'b0;
    #1 check("s6_we", {31'd0, bus.mem_we}, 32'd0);
    check("s6_busy", {31'd0, busy}, 32'd0);
    check("s6_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("s6_err", {31'd0, err}, 32'd0);
    check("s6_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("s6_data", bus.mem_wdata, 32'd0);
    check("s6_word_count", {23'd0, word_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    do_start(8'h60, 9'd1);
    push_byte(8'hCA);
    push_byte(8'hFE);
    push_byte(8'hF0);
    push_byte(8'h0D);
    wait_done(10);
    check("s6n_n_we", wa.size(), 32'd1);
    check("s6n_addr", {24'd0, wa[0]}, 32'h60);
    check("s6n_data", wd[0], 32'hCAFEF00D);
    check("s6n_word_count", {23'd0, word_count}, 32'd1);
    check("s6n_err", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
